// File: rtl/packet_fifo.sv
// Packet buffer with tentative writes: words become readable only on commit, and
// discard rewinds the uncommitted tail. Status flags are derived from registered pointers.
module packet_fifo #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 5,
  parameter int AF_LEVEL = (2**ASIZE) - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DSIZE-1:0] write_data,
  input  logic             write_enable,
  input  logic             commit,
  input  logic             discard,
  input  logic             read_enable,
  output logic [DSIZE-1:0] read_data,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ASIZE:0] DEPTH_P = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] ONE_P   = {{ASIZE{1'b0}}, 1'b1};
  localparam logic [ASIZE:0] ZERO_P  = {(ASIZE+1){1'b0}};
  localparam logic [ASIZE:0] AF_P    = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_P    = (ASIZE+1)'(AE_LEVEL);

  logic [DSIZE-1:0] mem_r [2**ASIZE];
  logic [ASIZE:0]   wr_ptr_r, cm_ptr_r, rd_ptr_r;
  logic [ASIZE:0]   wr_ptr_nxt_s, cm_ptr_nxt_s, rd_ptr_nxt_s, wr_ptr_post_s;
  logic [ASIZE:0]   occupancy_s, level_s;
  logic             full_s, empty_s, wr_accept_s, rd_accept_s;
  logic [DSIZE-1:0] read_data_r;
  logic             overflow_r, underflow_r;

  assign occupancy_s = wr_ptr_r - rd_ptr_r;
  assign level_s     = cm_ptr_r - rd_ptr_r;
  assign full_s      = (occupancy_s == DEPTH_P);
  assign empty_s     = (level_s == ZERO_P);

  // A write dropped by discard or clear never reaches memory or the pointer.
  assign wr_accept_s   = write_enable && !full_s && !discard && !clear;
  assign rd_accept_s   = read_enable && !empty_s && !clear;
  assign wr_ptr_post_s = wr_accept_s ? (wr_ptr_r + ONE_P) : wr_ptr_r;

  // Next-state pointer selection with clear > discard > commit priority.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_post_s;
    cm_ptr_nxt_s = cm_ptr_r;
    rd_ptr_nxt_s = rd_accept_s ? (rd_ptr_r + ONE_P) : rd_ptr_r;
    if (clear) begin
      wr_ptr_nxt_s = ZERO_P;
      cm_ptr_nxt_s = ZERO_P;
      rd_ptr_nxt_s = ZERO_P;
    end else if (discard) begin
      wr_ptr_nxt_s = cm_ptr_r;
    end else if (commit) begin
      cm_ptr_nxt_s = wr_ptr_post_s;
    end else begin
      cm_ptr_nxt_s = cm_ptr_r;
    end
  end

  // Pointer, read data and error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= ZERO_P;
      cm_ptr_r    <= ZERO_P;
      rd_ptr_r    <= ZERO_P;
      read_data_r <= {DSIZE{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      cm_ptr_r <= cm_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      if (clear) begin
        read_data_r <= {DSIZE{1'b0}};
        overflow_r  <= 1'b0;
        underflow_r <= 1'b0;
      end else begin
        if (rd_accept_s) begin
          read_data_r <= mem_r[rd_ptr_r[ASIZE-1:0]];
        end
        overflow_r  <= write_enable && full_s && !discard;
        underflow_r <= read_enable && empty_s;
      end
    end
  end

  // Storage write port; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (wr_accept_s && !rst) begin
      mem_r[wr_ptr_r[ASIZE-1:0]] <= write_data;
    end
  end

  assign read_data    = read_data_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign level        = level_s;
  assign almost_full  = (occupancy_s >= AF_P);
  assign almost_empty = (level_s <= AE_P);

  packet_fifo_checker #(.ASIZE(ASIZE)) u_checker (
    .clk       (clk),
    .rst       (rst),
    .occupancy (occupancy_s),
    .level     (level_s)
  );

endmodule

// Pointer-consistency properties: the committed region never exceeds the
// written region, and the written region never exceeds the storage depth.
module packet_fifo_checker #(
  parameter int ASIZE = 5
) (
  input logic           clk,
  input logic           rst,
  input logic [ASIZE:0] occupancy,
  input logic [ASIZE:0] level
);

  localparam logic [ASIZE:0] DEPTH_P = {1'b1, {ASIZE{1'b0}}};

  occupancy_bounded_a: assert property (@(posedge clk) disable iff (rst) occupancy <= DEPTH_P);
  level_within_occupancy_a: assert property (@(posedge clk) disable iff (rst) level <= occupancy);

endmodule
